pipeline_ctrl: RTL

- Central sequencer for the five-stage LC-3b pipeline (IF, ID, EX, MEM, WB).
- Drives the load enables and bubble-inserts for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB stage registers.
- Arbitrates three hazard sources:
  - outstanding instruction/data memory responses (freeze),
  - load-use dependencies on the EX-stage load (bubble),
  - taken control transfers resolved in MEM (redirect and flush).
- Latches single-cycle memory responses so that none are lost while the pipeline is frozen.

---
 rtl/pipeline_ctrl_pkg.sv | 44 ++++
 rtl/pipeline_ctrl_hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the LC-3b pipeline sequencer: register index, FSM state and
// the bundled stage-register control word with its four canned settings.
package pipeline_ctrl_pkg;

    localparam int DEFAULT_REG_W = 3;

    typedef logic [DEFAULT_REG_W-1:0] lc3b_reg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic load_pc;
        logic pcmux_sel;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FREEZE   = '0;
    localparam pipe_ctrl_t CTRL_ADVANCE  = '{load_pc: 1'b1, pcmux_sel: 1'b0,
                                             load_if_id: 1'b1, load_id_ex: 1'b1,
                                             load_ex_mem: 1'b1, load_mem_wb: 1'b1,
                                             flush_if_id: 1'b0, flush_id_ex: 1'b0,
                                             flush_ex_mem: 1'b0};
    // The branch itself stays in MEM_WB; everything younger becomes a bubble.
    localparam pipe_ctrl_t CTRL_REDIRECT = '{load_pc: 1'b1, pcmux_sel: 1'b1,
                                             load_if_id: 1'b1, load_id_ex: 1'b1,
                                             load_ex_mem: 1'b1, load_mem_wb: 1'b1,
                                             flush_if_id: 1'b1, flush_id_ex: 1'b1,
                                             flush_ex_mem: 1'b1};
    localparam pipe_ctrl_t CTRL_BUBBLE   = '{load_pc: 1'b0, pcmux_sel: 1'b0,
                                             load_if_id: 1'b0, load_id_ex: 1'b1,
                                             load_ex_mem: 1'b1, load_mem_wb: 1'b1,
                                             flush_if_id: 1'b0, flush_id_ex: 1'b1,
                                             flush_ex_mem: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational source/destination register match; used for the load-use check
// and reusable for forwarding selection.
module pipeline_ctrl_hazard_detect #(
    parameter int REG_W = 3
) (
    input  logic             dst_valid,
    input  logic [REG_W-1:0] dst,
    input  logic [REG_W-1:0] sr1,
    input  logic [REG_W-1:0] sr2,
    input  logic             use_sr1,
    input  logic             use_sr2,
    output logic             hit
);

    assign hit = dst_valid & ((use_sr1 & (sr1 == dst)) | (use_sr2 & (sr2 == dst)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage LC-3b pipeline sequencer: freeze on outstanding memory, load-use
// bubble, MEM-stage redirect. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W = 3
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_active,
    input  logic             dmem_resp,
    input  logic [REG_W-1:0] id_sr1,
    input  logic [REG_W-1:0] id_sr2,
    input  logic             id_use_sr1,
    input  logic             id_use_sr2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_dr,
    input  logic             mem_br_taken,
    output logic             load_pc,
    output logic             pcmux_sel,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
`ifdef PIPE_CTRL_PERF_EN
    input  logic             perf_clr,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] bubble_count,
    output logic [PERF_W-1:0] flush_count,
`endif
    output logic             stalled
);

    pipe_ctrl_state_t state_q, state_d;
    logic             imem_done_q, imem_done_d;
    logic             dmem_done_q, dmem_done_d;
    logic             imem_ok, dmem_ok, adv;
    logic             lu, redirect, bubble;
    pipe_ctrl_t       ctrl;

    pipeline_ctrl_hazard_detect #(.REG_W(REG_W)) u_hazard (
        .dst_valid (ex_valid & ex_is_load),
        .dst       (ex_dr),
        .sr1       (id_sr1),
        .sr2       (id_sr2),
        .use_sr1   (id_use_sr1),
        .use_sr2   (id_use_sr2),
        .hit       (lu)
    );

    assign imem_ok  = ~imem_read | imem_resp | imem_done_q;
    assign dmem_ok  = ~dmem_active | dmem_resp | dmem_done_q;
    assign adv      = imem_ok & dmem_ok;
    assign redirect = adv & mem_br_taken;
    assign bubble   = adv & ~mem_br_taken & lu;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (!adv) state_d = WAIT;
            WAIT:    if (adv)  state_d = RUN;
            default: state_d = RUN;
        endcase
        // A response arriving on an advancing cycle is consumed, not remembered.
        imem_done_d = adv ? 1'b0 : (imem_done_q | imem_resp);
        dmem_done_d = adv ? 1'b0 : (dmem_done_q | dmem_resp);
    end

    // Outputs are gated by rst_n so they drop immediately, even mid-stall.
    always_comb begin
        ctrl    = CTRL_FREEZE;
        stalled = 1'b0;
        if (rst_n) begin
            stalled = (state_q == WAIT);
            if (!adv)          ctrl = CTRL_FREEZE;
            else if (redirect) ctrl = CTRL_REDIRECT;
            else if (bubble)   ctrl = CTRL_BUBBLE;
            else               ctrl = CTRL_ADVANCE;
        end
    end

    assign load_pc      = ctrl.load_pc;
    assign pcmux_sel    = ctrl.pcmux_sel;
    assign load_if_id   = ctrl.load_if_id;
    assign load_id_ex   = ctrl.load_id_ex;
    assign load_ex_mem  = ctrl.load_ex_mem;
    assign load_mem_wb  = ctrl.load_mem_wb;
    assign flush_if_id  = ctrl.flush_if_id;
    assign flush_id_ex  = ctrl.flush_id_ex;
    assign flush_ex_mem = ctrl.flush_ex_mem;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_q, bubble_q, flush_q;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + PERF_W'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else if (perf_clr) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            stall_q  <= sat_inc(stall_q, ~adv);
            bubble_q <= sat_inc(bubble_q, bubble);
            flush_q  <= sat_inc(flush_q, redirect);
        end
    end

    assign stall_cycles = stall_q;
    assign bubble_count = bubble_q;
    assign flush_count  = flush_q;
`endif

endmodule
